dmem_responder: RTL



---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core and dmem_responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-state data memory responder with one outstanding request.
// Optional TOHOST register enabled by defining DMEM_TOHOST_EN.
module dmem_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    dmem_responder_if.slave bus,
    output logic [31:0] tohost_data,
    output logic        tohost_done
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int DEPTH = 1 << (ADDR_W - 2);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        enter_resp;
    logic        accept;
    logic        we_q;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        in_range;
    logic        is_tohost;
    logic [ADDR_W-3:0] idx;
    logic [31:0] mem [DEPTH];

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign accept   = bus.req_valid && bus.req_ready;
    assign in_range = (addr_q[31:ADDR_W] == '0);
    assign idx      = addr_q[ADDR_W-1:2];

`ifdef DMEM_TOHOST_EN
    assign is_tohost = (addr_q == 30'h3FFF_FFFC);
`else
    assign is_tohost = 1'b0;
`endif

    // WAIT always spends one extra cycle so the access lands WAIT_CYCLES+1 after accept
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end
            end
            WAIT: begin
                cnt_nx = cnt + 4'd1;
                if (cnt == WC) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr[31:2];
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            bus.rsp_err <= !in_range && !is_tohost;
            if (we_q || !(in_range || is_tohost))
                bus.rsp_rdata <= '0;
            else if (is_tohost)
                bus.rsp_rdata <= tohost_data;
            else
                bus.rsp_rdata <= mem[idx];
        end
    end

    // RAM is never reset; a reset on the access edge suppresses the write
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && we_q && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

`ifdef DMEM_TOHOST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_data <= '0;
            tohost_done <= 1'b0;
        end else if (enter_resp && we_q && is_tohost) begin
            tohost_data <= wdata_q;
            tohost_done <= 1'b1;
        end
    end
`else
    assign tohost_data = '0;
    assign tohost_done = 1'b0;
`endif
endmodule
